// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART byte width and block serializer FSM states
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP,
    FINISH
  } ser_state_t;

endpackage

// File: rtl/uart_block_serializer_if.sv
// rtl/uart_block_serializer_if.sv - block input and UART transmitter handshake bundle
// slave  : serializer side (takes block + tx ready, drives ready/start/byte/busy/done)
// master : producer/transmitter side
interface uart_block_serializer_if
  import uart_pkg::*;
#(
  parameter int NUM_BYTES = 16
);

  logic [UART_BYTE_W*NUM_BYTES-1:0] blk_data;
  logic                             blk_valid;
  logic                             blk_ready;
  logic                             uart_tx_ready;
  logic                             uart_tx_start;
  logic [UART_BYTE_W-1:0]           uart_transmit_data;
  logic                             busy;
  logic                             done;

  modport master (
    output blk_data, blk_valid, uart_tx_ready,
    input  blk_ready, uart_tx_start, uart_transmit_data, busy, done
  );

  modport slave (
    input  blk_data, blk_valid, uart_tx_ready,
    output blk_ready, uart_tx_start, uart_transmit_data, busy, done
  );

endinterface

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte idle gap timer
// uart_clock/uart_reset : clock, synchronous active-low reset
// i_load                : arm the timer for a fresh gap
// i_count_en            : count down while the gap is in progress
// o_expired             : gap has elapsed
module uart_gap_timer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic uart_clock,
  input  logic uart_reset,
  input  logic i_load,
  input  logic i_count_en,
  output logic o_expired
);

  // Loading GAP_CYCLES-1 makes the gap state last exactly GAP_CYCLES clocks,
  // since expiry is seen in the last of them.
  localparam logic [15:0] LOAD_VAL = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  logic [15:0] r_count;

  always_ff @(posedge uart_clock) begin
    if (!uart_reset) begin
      r_count <= 16'd0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_count_en && (r_count != 16'd0)) begin
      r_count <= r_count - 16'd1;
    end
  end

  assign o_expired = (r_count == 16'd0);

endmodule

// File: rtl/uart_block_serializer.sv
// rtl/uart_block_serializer.sv - sends a NUM_BYTES block to a UART transmitter, MSB byte first
// uart_clock/uart_reset : clock, synchronous active-low reset
// bus (slave)           : blk_data/blk_valid/blk_ready block input, uart_tx_ready/uart_tx_start/
//                         uart_transmit_data transmitter handshake, busy and done status
module uart_block_serializer
  import uart_pkg::*;
#(
  parameter int NUM_BYTES  = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                    uart_clock,
  input  logic                    uart_reset,
  uart_block_serializer_if.slave  bus
);

  localparam int BLK_W = UART_BYTE_W * NUM_BYTES;
  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  ser_state_t       r_state;
  ser_state_t       w_next;
  logic [BLK_W-1:0] r_shift;
  logic [CNT_W-1:0] r_count;

  logic w_capture;
  logic w_advance;
  logic w_gap_load;
  logic w_gap_expired;
  logic w_blk_ready;
  logic w_tx_start;
  logic w_busy;
  logic w_done;

  uart_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .uart_clock (uart_clock),
    .uart_reset (uart_reset),
    .i_load     (w_gap_load),
    .i_count_en (r_state == GAP),
    .o_expired  (w_gap_expired)
  );

  always_ff @(posedge uart_clock) begin
    if (!uart_reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_shift <= bus.blk_data;
        r_count <= '0;
      end else if (w_advance) begin
        r_shift <= r_shift << UART_BYTE_W;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_gap_load  = 1'b0;
    w_blk_ready = 1'b0;
    w_tx_start  = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_blk_ready = 1'b1;
        w_busy      = 1'b0;
        if (bus.blk_valid) begin
          w_capture = 1'b1;
          w_next    = START;
        end
      end
      START: begin
        if (bus.uart_tx_ready) begin
          w_tx_start = 1'b1;
          w_next     = WAIT_BUSY;
        end
      end
      // Transmitter drops ready once it has taken the byte.
      WAIT_BUSY: begin
        if (!bus.uart_tx_ready) begin
          w_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.uart_tx_ready) begin
          if (r_count == LAST_IDX) begin
            w_next = FINISH;
          end else begin
            w_advance = 1'b1;
            if (GAP_CYCLES == 0) begin
              w_next = START;
            end else begin
              w_gap_load = 1'b1;
              w_next     = GAP;
            end
          end
        end
      end
      GAP: begin
        if (w_gap_expired) begin
          w_next = START;
        end
      end
      FINISH: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign bus.blk_ready          = w_blk_ready;
  assign bus.uart_tx_start      = w_tx_start;
  assign bus.uart_transmit_data = r_shift[BLK_W-1 -: UART_BYTE_W];
  assign bus.busy               = w_busy;
  assign bus.done               = w_done;

endmodule

// File: tb/tb_uart_block_serializer.sv
// tb/tb_uart_block_serializer.sv - self-checking bench for uart_block_serializer
module tb_uart_block_serializer;

  localparam int NB   = 16;
  localparam int BW   = 8 * NB;
  localparam int LOGN = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_block_serializer_if #(.NUM_BYTES(NB)) bus0 ();
  uart_block_serializer_if #(.NUM_BYTES(NB)) bus1 ();

  uart_block_serializer #(.NUM_BYTES(NB), .GAP_CYCLES(0)) dut0 (
    .uart_clock (clk),
    .uart_reset (rst_n),
    .bus        (bus0)
  );

  uart_block_serializer #(.NUM_BYTES(NB), .GAP_CYCLES(5)) dut1 (
    .uart_clock (clk),
    .uart_reset (rst_n),
    .bus        (bus1)
  );

  logic [BW-1:0] d_data [2] = '{'0, '0};
  logic          d_valid[2] = '{1'b0, 1'b0};
  logic          hold_low[2] = '{1'b0, 1'b0};
  logic          tx_busy[2] = '{1'b0, 1'b0};
  logic          tx_pend[2] = '{1'b0, 1'b0};
  int            tx_cnt[2]  = '{0, 0};
  logic          tx_ready[2];
  logic          o_ready[2], o_start[2], o_busy[2], o_done[2];
  logic [7:0]    o_byte[2];

  assign tx_ready[0] = !tx_busy[0] && !hold_low[0];
  assign tx_ready[1] = !tx_busy[1] && !hold_low[1];

  assign bus0.blk_data      = d_data[0];
  assign bus0.blk_valid     = d_valid[0];
  assign bus0.uart_tx_ready = tx_ready[0];
  assign bus1.blk_data      = d_data[1];
  assign bus1.blk_valid     = d_valid[1];
  assign bus1.uart_tx_ready = tx_ready[1];

  assign o_ready[0] = bus0.blk_ready;
  assign o_start[0] = bus0.uart_tx_start;
  assign o_byte[0]  = bus0.uart_transmit_data;
  assign o_busy[0]  = bus0.busy;
  assign o_done[0]  = bus0.done;
  assign o_ready[1] = bus1.blk_ready;
  assign o_start[1] = bus1.uart_tx_start;
  assign o_byte[1]  = bus1.uart_transmit_data;
  assign o_busy[1]  = bus1.busy;
  assign o_done[1]  = bus1.done;

  // Transmitter model and event log: after a start pulse, ready drops on the
  // following cycle and stays low for 10 clocks.
  logic [7:0] cap_bytes[2][LOGN];
  int         gaps[2][LOGN];
  int         done_cyc[2][LOGN];
  int         acc_cyc[2][LOGN];
  int         nbytes[2]   = '{0, 0};
  int         ngaps[2]    = '{0, 0};
  int         ndone[2]    = '{0, 0};
  int         nacc[2]     = '{0, 0};
  int         rise_cyc[2] = '{0, 0};
  logic       prev_rdy[2] = '{1'b1, 1'b1};
  logic       armed[2]    = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic       s_start, s_done, s_acc, rdy;
      logic [7:0] s_byte;
      s_start = o_start[d];
      s_done  = o_done[d];
      s_acc   = o_ready[d] && d_valid[d];
      s_byte  = o_byte[d];
      if (tx_pend[d]) begin
        tx_pend[d] = 1'b0;
        tx_busy[d] = 1'b1;
        tx_cnt[d]  = 10;
      end else if (tx_busy[d]) begin
        tx_cnt[d] = tx_cnt[d] - 1;
        if (tx_cnt[d] == 0) tx_busy[d] = 1'b0;
      end
      if (s_start) begin
        tx_pend[d] = 1'b1;
        if (nbytes[d] < LOGN) cap_bytes[d][nbytes[d]] = s_byte;
        nbytes[d] = nbytes[d] + 1;
        if (armed[d] && ngaps[d] < LOGN) begin
          gaps[d][ngaps[d]] = cyc - rise_cyc[d];
          ngaps[d] = ngaps[d] + 1;
        end
        armed[d] = 1'b1;
      end
      if (s_done) begin
        if (ndone[d] < LOGN) done_cyc[d][ndone[d]] = cyc;
        ndone[d] = ndone[d] + 1;
        armed[d] = 1'b0;
      end
      if (s_acc) begin
        if (nacc[d] < LOGN) acc_cyc[d][nacc[d]] = cyc;
        nacc[d] = nacc[d] + 1;
      end
      if (!rst_n) armed[d] = 1'b0;
      rdy = !tx_busy[d] && !hold_low[d];
      if (rdy && !prev_rdy[d]) rise_cyc[d] = cyc;
      prev_rdy[d] = rdy;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nchk = nchk + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one block and checks the full byte stream, gaps and completion.
  task automatic send_block(input int d, input logic [BW-1:0] data, input int hold, input int poke,
                            input logic [7:0] exp_first, input logic [7:0] exp_last,
                            input int exp_gap, input string tag);
    int b0, g0, n0, t, gmin, gmax;
    logic [BW-1:0] got;
    logic poked;
    b0 = nbytes[d]; g0 = ngaps[d]; n0 = ndone[d]; poked = 1'b0;
    if (hold > 0) hold_low[d] = 1'b1;
    t = 0;
    while (!o_ready[d] && t < 200) begin @(posedge clk); #1; t++; end
    chk({tag, "_idle_ready"}, o_ready[d], 1);
    d_data[d] = data; d_valid[d] = 1'b1;
    @(posedge clk); #1;
    d_valid[d] = 1'b0;
    chk({tag, "_busy_after_accept"}, o_busy[d], 1);
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk({tag, "_no_start_while_tx_not_ready"}, nbytes[d] - b0, 0);
      hold_low[d] = 1'b0;
    end
    t = 0;
    while (ndone[d] == n0 && t < 2000) begin
      @(posedge clk); #1; t++;
      if (poke >= 0 && !poked && (nbytes[d] - b0) > poke) begin
        d_data[d] = ~data; d_valid[d] = 1'b1; poked = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ready_low_during_poke"}, o_ready[d], 0);
        d_valid[d] = 1'b0;
      end
    end
    chk({tag, "_done_within_bound"}, t < 2000, 1);
    chk({tag, "_ready_after_done"}, o_ready[d], 1);
    chk({tag, "_busy_after_done"}, o_busy[d], 0);
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_done_pulses"}, ndone[d] - n0, 1);
    chk({tag, "_start_pulses"}, nbytes[d] - b0, NB);
    got = '0;
    for (int i = 0; i < NB; i++) begin
      if (b0 + i < LOGN) got = {got[BW-9:0], cap_bytes[d][b0 + i]};
    end
    chk({tag, "_byte_stream"}, got, data);
    chk({tag, "_first_byte"}, got[BW-1 -: 8], exp_first);
    chk({tag, "_last_byte"}, got[7:0], exp_last);
    chk({tag, "_gap_count"}, ngaps[d] - g0, NB - 1);
    gmin = 1 << 30; gmax = -1;
    for (int i = g0; i < ngaps[d] && i < LOGN; i++) begin
      if (gaps[d][i] < gmin) gmin = gaps[d][i];
      if (gaps[d][i] > gmax) gmax = gaps[d][i];
    end
    chk({tag, "_gap_min"}, gmin, exp_gap);
    chk({tag, "_gap_max"}, gmax, exp_gap);
  endtask

  typedef struct {
    logic [BW-1:0] data;
    int            dut;
    int            hold;
    int            poke;
    logic [7:0]    exp_first;
    logic [7:0]    exp_last;
    int            exp_gap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [BW-1:0] blk_a, blk_b;
    int b0, n0, a0, t;

    // exp_gap: clocks from the cycle ready rises to the next start pulse;
    // one detection clock plus GAP_CYCLES idle clocks (0 for dut0, 5 for dut1).
    vecs[0] = '{128'h00112233445566778899AABBCCDDEEFF, 0, 0,  -1, 8'h00, 8'hFF, 1};
    vecs[1] = '{128'h00112233445566778899AABBCCDDEEFF, 1, 0,  -1, 8'h00, 8'hFF, 6};
    vecs[2] = '{128'hDEADBEEF0123456789ABCDEFFEDCBA98, 0, 20, -1, 8'hDE, 8'h98, 1};
    vecs[3] = '{128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 0, 0,   3, 8'h0F, 8'hF0, 1};
    vecs[4] = '{128'h80000000000000000000000000000001, 1, 0,  -1, 8'h80, 8'h01, 6};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_blk_ready", o_ready[0], 1);
    chk("reset_busy", o_busy[0], 0);
    chk("reset_done", o_done[0], 0);
    chk("reset_tx_start", o_start[0], 0);
    chk("reset_tx_data", o_byte[0], 8'h00);
    chk("reset_blk_ready_gap_dut", o_ready[1], 1);

    for (int i = 0; i < 5; i++) begin
      send_block(vecs[i].dut, vecs[i].data, vecs[i].hold, vecs[i].poke,
                 vecs[i].exp_first, vecs[i].exp_last, vecs[i].exp_gap, $sformatf("vec%0d", i));
    end

    // Reset in WAIT_DONE of byte 7.
    blk_a = 128'h112233445566778899AABBCCDDEEFF00;
    b0 = nbytes[0];
    d_data[0] = blk_a; d_valid[0] = 1'b1;
    @(posedge clk); #1;
    d_valid[0] = 1'b0;
    t = 0;
    while ((nbytes[0] - b0) < 8 && t < 1000) begin @(posedge clk); #1; t++; end
    while (tx_ready[0] && t < 1000) begin @(posedge clk); #1; t++; end
    chk("rst_reach_byte7", t < 1000, 1);
    repeat (3) begin @(posedge clk); #1; end
    n0 = ndone[0];
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_blk_ready", o_ready[0], 1);
    chk("rst_mid_busy", o_busy[0], 0);
    chk("rst_mid_tx_data", o_byte[0], 8'h00);
    chk("rst_mid_tx_start", o_start[0], 0);
    chk("rst_mid_done", o_done[0], 0);
    repeat (30) begin @(posedge clk); #1; end
    chk("rst_mid_no_done", ndone[0] - n0, 0);
    send_block(0, 128'h5A5A0102A5A50304C3C30506F0F00708, 0, -1, 8'h5A, 8'h08, 1, "after_rst");

    // Two blocks held valid back-to-back.
    blk_a = 128'h0102030405060708090A0B0C0D0E0F10;
    blk_b = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    b0 = nbytes[0]; n0 = ndone[0]; a0 = nacc[0];
    d_data[0] = blk_a; d_valid[0] = 1'b1;
    @(posedge clk); #1;
    d_data[0] = blk_b;
    t = 0;
    while ((nacc[0] - a0) < 2 && t < 2000) begin @(posedge clk); #1; t++; end
    d_valid[0] = 1'b0;
    while ((ndone[0] - n0) < 2 && t < 4000) begin @(posedge clk); #1; t++; end
    chk("b2b_within_bound", t < 4000, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("b2b_done_pulses", ndone[0] - n0, 2);
    chk("b2b_accepts", nacc[0] - a0, 2);
    chk("b2b_byte_count", nbytes[0] - b0, 2 * NB);
    blk_a = '0; blk_b = '0;
    for (int i = 0; i < NB; i++) begin
      if (b0 + NB + i < LOGN) begin
        blk_a = {blk_a[BW-9:0], cap_bytes[0][b0 + i]};
        blk_b = {blk_b[BW-9:0], cap_bytes[0][b0 + NB + i]};
      end
    end
    chk("b2b_first_block", blk_a, 128'h0102030405060708090A0B0C0D0E0F10);
    chk("b2b_second_block", blk_b, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    if (a0 + 1 < LOGN && n0 < LOGN)
      chk("b2b_accept_first_idle", acc_cyc[0][a0 + 1], done_cyc[0][n0] + 1);
    else
      chk("b2b_log_space", 0, 1);
    chk("b2b_ready_end", o_ready[0], 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_block_serializer.md
UART_BLOCK_SERIALIZER -- requirements
Module: uart_block_serializer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16: bytes per block (block width = 8*NUM_BYTES).
REQ-002 SHALL have parameter GAP_CYCLES, default 0: idle clocks inserted between consecutive bytes, 16-bit range.
REQ-003 SHALL have port uart_clock  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port uart_reset  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port blk_data  in  8*NUM_BYTES  block to transmit, e.g. AES ciphertext.
REQ-006 SHALL have port blk_valid  in  1  blk_data is valid.
REQ-007 SHALL have port blk_ready  out  1  block can be accepted.
REQ-008 SHALL have port uart_tx_ready  in  1  UART transmitter is idle.
REQ-009 SHALL have port uart_tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port uart_transmit_data  out  8  byte presented to the UART transmitter.
REQ-011 SHALL have port busy  out  1  a block is being serialized.
REQ-012 SHALL have port done  out  1  one-cycle pulse after the last byte completes.

Function
REQ-013 SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE, GAP, FINISH.
REQ-014 IDLE: blk_ready=1; blk_valid&blk_ready captures blk_data into an internal shift register, clears the byte counter, and goes to START.
REQ-015 Byte order SHALL be MSB first: first byte = blk_data[8*NUM_BYTES-1 -: 8], last byte = blk_data[7:0].
REQ-016 START: waits for uart_tx_ready=1, then asserts uart_tx_start for exactly one cycle and goes to WAIT_BUSY.
REQ-017 WAIT_BUSY: waits for uart_tx_ready=0 (transmitter acknowledged), then goes to WAIT_DONE.
REQ-018 WAIT_DONE: waits for uart_tx_ready=1; if counter = NUM_BYTES-1, goes to FINISH; else shifts the register by 8 bits, increments the counter, and goes to GAP (or to START when GAP_CYCLES=0).
REQ-019 GAP: counts GAP_CYCLES clocks, then goes to START.
REQ-020 FINISH: pulses done for one cycle and goes to IDLE; blk_ready returns high the following cycle.
REQ-021 uart_transmit_data SHALL be the current byte and SHALL remain stable from START entry until WAIT_DONE exit.
REQ-022 blk_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE.
REQ-023 blk_valid while not in IDLE SHALL be ignored; blk_data changes after capture SHALL not affect the output.
REQ-024 Byte counter width SHALL be $clog2(NUM_BYTES); it never exceeds NUM_BYTES-1.
REQ-025 Back-to-back blocks: after FINISH, a block held valid SHALL be accepted in the first IDLE cycle.

Reset
REQ-026 On uart_reset=0 at a clock edge, the FSM SHALL go to IDLE, regardless of state, including mid-byte.
REQ-027 Reset values: blk_ready=1 from the first cycle after reset release; busy=0; done=0; uart_tx_start=0; uart_transmit_data=8'h00; counter=0; shift register=0.

Structure
REQ-028 The FSM state enum SHALL live in a shared package, uart_pkg, alongside the UART byte width constant (8).
REQ-029 Gap timing SHALL be a single sub-module, uart_gap_timer (load/count/expire), instanced once; everything else is flat.

Verification
REQ-030 Reset, then blk_data=128'h00112233445566778899AABBCCDDEEFF with a transmitter model (ready low 10 cycles after start) -> 16 start pulses, bytes 00,11,...,FF in order, one done pulse, blk_ready high after.
REQ-031 GAP_CYCLES=5 -> exactly 5 idle clocks from ready rising to the next start pulse.
REQ-032 uart_tx_ready held low for 20 cycles at block accept -> no start pulse until ready=1, then exactly one.
REQ-033 blk_valid pulsed with a new value during byte 3 -> ignored; output bytes unchanged; blk_ready stays 0.
REQ-034 uart_reset=0 for 1 cycle during WAIT_DONE of byte 7 -> next cycle IDLE, outputs at reset values, no done pulse; a new block then transmits all 16 bytes.
REQ-035 Two blocks held back-to-back valid -> 32 bytes in order, two done pulses, no duplicated or dropped byte.
